vga_palette_scanout: RTL and testbench
======================================

Name: vga_palette_scanout

Overview:
- Pixel-clock display scanout engine that sits directly downstream of the wishbone colour palette RAM.
- Generates VGA timing and sequential framebuffer read addresses.
- Forwards each returned framebuffer byte as the palette read-only index.
- Registers the palette's r/g/b together with hsync/vsync/de, all delayed to line up, onto the VGA pins.

Parameters:
- h_active, 640, visible pixels per line
- h_fp, 16, horizontal front porch (clocks)
- h_sync, 96, hsync pulse width (clocks)
- h_bp, 48, horizontal back porch (clocks)
- v_active, 480, visible lines per frame
- v_fp, 10, vertical front porch (lines)
- v_sync, 2, vsync pulse width (lines)
- v_bp, 33, vertical back porch (lines)
- sync_pol, 0, sync active level (0 = active-low, 1 = active-high)
- fb_aw, 19, framebuffer address width; must satisfy 2^fb_aw >= h_active*v_active
- pal_aw, 6, palette index width (palette addr_width-2)

Ports:
- clk  in  1  pixel clock; same clock drives the palette read port (clk2)
- rst  in  1  asynchronous, active-high reset
- en  in  1  scanout enable
- fb_addr  out  fb_aw  framebuffer read address
- fb_rd  out  1  framebuffer read strobe
- fb_data  in  8  framebuffer pixel index; valid 1 clk after fb_addr/fb_rd
- pal_addr  out  pal_aw  palette read index; equals fb_data[pal_aw-1:0], combinational
- pal_r  in  8  palette red; valid 1 clk after pal_addr
- pal_g  in  8  palette green; valid 1 clk after pal_addr
- pal_b  in  8  palette blue; valid 1 clk after pal_addr
- vga_r  out  8  registered red
- vga_g  out  8  registered green
- vga_b  out  8  registered blue
- vga_hs  out  1  registered hsync
- vga_vs  out  1  registered vsync
- vga_de  out  1  registered display enable
- frame_start  out  1  one-clock pulse on the first active pixel of a frame, aligned with the vga_* outputs

Behaviour:
- Totals: h_total = h_active+h_fp+h_sync+h_bp; v_total likewise.
- Counters: h_cnt runs 0..h_total-1 and advances every clk while en=1. Its wrap advances v_cnt, which runs 0..v_total-1 and wraps to 0.
- Stage 0, combinational from the counters:
  - de0 = (h_cnt<h_active)&&(v_cnt<v_active)
  - hs0 is active when h_active+h_fp <= h_cnt < h_active+h_fp+h_sync
  - vs0 is active when v_active+v_fp <= v_cnt < v_active+v_fp+v_sync; vs0 is line-based, so it changes only at the h_cnt wrap
  - fs0 = (h_cnt==0)&&(v_cnt==0)
- Address counter:
  - fb_addr is a registered counter that increments after each clk with de0=1.
  - It clears to 0 on the clk where h_cnt==h_total-1 and v_cnt==v_total-1. No multiplier is used.
  - Last address in a frame = h_active*v_active-1.
- Read strobe: fb_rd = de0 & en & ~rst.
- Pipeline: de/hs/vs/fs delay line of 3 registers.
  - Stage 1: fb_data returns; pal_addr follows it combinationally.
  - Stage 2: pal_r/g/b are valid.
  - Stage 3 (output regs): vga_r/g/b <= de2 ? pal_* : 0; vga_de <= de2; vga_hs/vs <= hs2/vs2 mapped to sync_pol; frame_start <= fs2.
- Total latency: counter position -> pins = 3 clks. Colours are forced to 0 whenever vga_de=0.
- Reset (async, rst=1):
  - h_cnt, v_cnt, fb_addr = 0.
  - Delay line cleared, with hs/vs holding the inactive level.
  - vga_r/g/b = 0, vga_de = 0, frame_start = 0.
  - vga_hs and vga_vs = inactive level (= ~sync_pol).
  - fb_rd = 0.
- en=0:
  - Counters and fb_addr clear to 0 on the next clk and hold there. fb_rd = 0.
  - The delay line keeps shifting in de=0 with syncs inactive, so the pins blank within 3 clks.
  - Re-asserting en starts a frame at (0,0), with frame_start seen 3 clks later.
- Reset mid-frame: same as en=0, except it takes effect immediately and asynchronously. After release the next frame starts cleanly at address 0.
- Boundary cases:
  - fb_addr never exceeds h_active*v_active-1.
  - Simultaneous h wrap and v wrap: v_cnt -> 0 and fb_addr -> 0 on the same clk.
  - The first line after vertical blanking reads address h_active*v_active only if the clear is missed. That is a failure.

Test Plan:
- Small timing (h 8/2/3/3, v 4/1/2/1, sync_pol=0), en=1 after reset. Requirements:
  - vga_de high for 8 clks every 16.
  - vga_hs low for exactly clks 10..12 of each line, measured at counter time +3.
  - vga_vs low for lines 5..6.
  - A frame lasts 128 clks.
- Framebuffer model returns fb_data = addr[7:0]; palette model returns r = idx, g = ~idx, b = 0x55 with 1-clk latency. Requirements:
  - The pixel at (x=3,y=2) appears on the pins as r=0x13, g=0xEC, b=0x55.
  - vga_de=1 for that pixel.
- Address sequence: fb_addr walks 0..31 across the 4 active lines, holds during blanking, and returns to 0 at the frame boundary; 3 consecutive frames are checked. frame_start pulses once per frame, coincident with the first vga_de.
- Blanking: palette model drives 0xFF on all channels constantly. Requirement: vga_r/g/b = 0 on every clk with vga_de=0.
- Drop en at pixel (5,1). Requirements:
  - fb_rd = 0 on the next clk.
  - Pins blank (de=0, colours 0, hs=vs=1) within 3 clks.
  - After en=1, the first output pixel comes from fb_addr 0, and frame_start fires.
- Assert rst asynchronously mid-line (between clk edges). Requirement: all outputs take their reset values immediately (colours 0, de 0, hs/vs 1). After release, scanout restarts at (0,0) with fb_addr 0.

Source files
------------

// File: rtl/vga_palette_scanout.sv
// VGA scanout engine: timing counters, sequential framebuffer addressing, and a
// 3-stage control delay line that lines up sync/de with the palette colour data.
module vga_palette_scanout #(
    parameter int h_active = 640,
    parameter int h_fp     = 16,
    parameter int h_sync   = 96,
    parameter int h_bp     = 48,
    parameter int v_active = 480,
    parameter int v_fp     = 10,
    parameter int v_sync   = 2,
    parameter int v_bp     = 33,
    parameter bit sync_pol = 1'b0,
    parameter int fb_aw    = 19,
    parameter int pal_aw   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [fb_aw-1:0]  fb_addr,
    output logic              fb_rd,
    input  logic [7:0]        fb_data,
    output logic [pal_aw-1:0] pal_addr,
    input  logic [7:0]        pal_r,
    input  logic [7:0]        pal_g,
    input  logic [7:0]        pal_b,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              frame_start
);

    localparam int H_TOTAL = h_active + h_fp + h_sync + h_bp;
    localparam int V_TOTAL = v_active + v_fp + v_sync + v_bp;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0]    H_ACT  = HW'(h_active);
    localparam logic [HW-1:0]    H_SS   = HW'(h_active + h_fp);
    localparam logic [HW-1:0]    H_SE   = HW'(h_active + h_fp + h_sync);
    localparam logic [HW-1:0]    H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT  = VW'(v_active);
    localparam logic [VW-1:0]    V_SS   = VW'(v_active + v_fp);
    localparam logic [VW-1:0]    V_SE   = VW'(v_active + v_fp + v_sync);
    localparam logic [VW-1:0]    V_LAST = VW'(V_TOTAL - 1);
    localparam logic [fb_aw-1:0] FB_LAST = fb_aw'(h_active * v_active - 1);

    // Control bits are stored as "active" flags; all-zero is the blank, sync-inactive state.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } ctl_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          frame_end;
    ctl_t          ctl0, ctl1, ctl2;
    logic          fb_data_unused;

    // Stage 0 is gated by en so a disabled engine feeds blanks into the delay line.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ctl0      = '0;
        h_wrap    = (h_cnt == H_LAST);
        frame_end = h_wrap && (v_cnt == V_LAST);
        if (en) begin
            ctl0.de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            ctl0.hs = (h_cnt >= H_SS) && (h_cnt < H_SE);
            ctl0.vs = (v_cnt >= V_SS) && (v_cnt < V_SE);
            ctl0.fs = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign fb_rd          = ctl0.de && !rst;
    assign pal_addr       = fb_data[pal_aw-1:0];
    assign fb_data_unused = ^fb_data[7:pal_aw];

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            fb_addr <= '0;
        end else if (!en) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            fb_addr <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            // The address saturates at the last pixel and is cleared only at the frame boundary.
            if (frame_end)
                fb_addr <= '0;
            else if (ctl0.de && (fb_addr != FB_LAST))
                fb_addr <= fb_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl1        <= '0;
            ctl2        <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_de      <= 1'b0;
            vga_hs      <= ~sync_pol;
            vga_vs      <= ~sync_pol;
            frame_start <= 1'b0;
        end else begin
            ctl1        <= ctl0;
            ctl2        <= ctl1;
            vga_r       <= ctl2.de ? pal_r : 8'h00;
            vga_g       <= ctl2.de ? pal_g : 8'h00;
            vga_b       <= ctl2.de ? pal_b : 8'h00;
            vga_de      <= ctl2.de;
            vga_hs      <= ctl2.hs ? sync_pol : ~sync_pol;
            vga_vs      <= ctl2.vs ? sync_pol : ~sync_pol;
            frame_start <= ctl2.fs;
        end
    end

endmodule

// File: tb/tb_vga_palette_scanout.sv
// Scoreboard bench for vga_palette_scanout on a 16x8-clock small timing with
// behavioural framebuffer/palette models and randomized enable drops.
module tb_vga_palette_scanout;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LAST_ADDR = HA * VA - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] fb_addr;
    logic       fb_rd;
    logic [7:0] fb_data;
    logic [5:0] pal_addr;
    logic [7:0] pal_r, pal_g, pal_b;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de, frame_start;
    bit         pal_ff = 1'b0;

    vga_palette_scanout #(
        .h_active(HA), .h_fp(HF), .h_sync(HS), .h_bp(HB),
        .v_active(VA), .v_fp(VF), .v_sync(VS), .v_bp(VB),
        .sync_pol(1'b0), .fb_aw(8), .pal_aw(6)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
        .pal_addr(pal_addr), .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // External memories: framebuffer returns its own address, palette maps index to colours.
    always @(posedge clk) fb_data <= fb_addr;
    always @(posedge clk) begin
        pal_r <= pal_ff ? 8'hFF : {2'b00, pal_addr};
        pal_g <= pal_ff ? 8'hFF : ~{2'b00, pal_addr};
        pal_b <= pal_ff ? 8'hFF : 8'h55;
    end

    typedef struct {
        bit         de, hs, vs, fs, ff;
        logic [7:0] r, g, b;
        int         pos;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    bit   active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pin state for a raster position t (0..FRAME-1) while enabled.
    function automatic exp_t model(input int tt, input bit e, input bit ff);
        int   x = tt % HT;
        int   y = tt / HT;
        logic [7:0] idx;
        exp_t m;
        m.pos = e ? tt : -1;
        m.ff  = ff;
        m.de  = e && (x < HA) && (y < VA);
        m.hs  = !(e && (x >= HA + HF) && (x < HA + HF + HS));
        m.vs  = !(e && (y >= VA + VF) && (y < VA + VF + VS));
        m.fs  = e && (tt == 0);
        idx   = 8'((y * HA + x) % 64);
        m.r   = !m.de ? 8'h00 : (ff ? 8'hFF : idx);
        m.g   = !m.de ? 8'h00 : (ff ? 8'hFF : ~idx);
        m.b   = !m.de ? 8'h00 : (ff ? 8'hFF : 8'h55);
        return m;
    endfunction

    // Address presented at position tt: pixels already read this frame, saturated at the last one.
    function automatic int exp_addr(input int tt);
        int x = tt % HT;
        int y = tt / HT;
        int n;
        if (y >= VA)      n = HA * VA;
        else if (x >= HA) n = y * HA + HA;
        else              n = y * HA + x;
        return (n > LAST_ADDR) ? LAST_ADDR : n;
    endfunction

    task automatic cycle(input bit e);
        en = e;
        sb.push_back(model(t, e, pal_ff));
        #1;
        check("fb_rd", 32'(fb_rd), 32'(e && model(t, e, pal_ff).de));
        check("fb_addr_max", 32'(fb_addr <= 8'(LAST_ADDR)), 32'd1);
        if (e) check("fb_addr", 32'(fb_addr), 32'(exp_addr(t)));
        @(posedge clk);
        t = e ? (t + 1) % FRAME : 0;
        @(negedge clk);
    endtask

    // After reset the delay line holds two blank stages before fresh positions reach the pins.
    task automatic release_rst();
        rst = 1'b0;
        t   = 0;
        sb.push_back(model(0, 1'b0, 1'b0));
        sb.push_back(model(0, 1'b0, 1'b0));
        active = 1'b1;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_de"}, 32'(vga_de), 32'd0);
        check({tag, "_hs"}, 32'(vga_hs), 32'd1);
        check({tag, "_vs"}, 32'(vga_vs), 32'd1);
        check({tag, "_rgb"}, {8'h00, vga_r, vga_g, vga_b}, 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_fb_rd"}, 32'(fb_rd), 32'd0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (active) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("vga_de", 32'(vga_de), 32'(e.de));
                    check("vga_hs", 32'(vga_hs), 32'(e.hs));
                    check("vga_vs", 32'(vga_vs), 32'(e.vs));
                    check("frame_start", 32'(frame_start), 32'(e.fs));
                    check("vga_r", 32'(vga_r), 32'(e.r));
                    check("vga_g", 32'(vga_g), 32'(e.g));
                    check("vga_b", 32'(vga_b), 32'(e.b));
                    if (e.pos == 2 * HT + 3 && !e.ff) begin
                        check("pix32_r", 32'(vga_r), 32'h13);
                        check("pix32_g", 32'(vga_g), 32'hEC);
                        check("pix32_b", 32'(vga_b), 32'h55);
                        check("pix32_de", 32'(vga_de), 32'd1);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        #12;
        check_reset_pins("reset");
        @(negedge clk);
        release_rst();

        // Three full frames of continuous scanout.
        repeat (3 * FRAME) cycle(1'b1);

        // Drop enable at pixel (5,1); swap in the all-0xFF palette while blanked.
        while (t != HT + 5) cycle(1'b1);
        cycle(1'b0);
        pal_ff = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        check("endrop_de", 32'(vga_de), 32'd0);
        check("endrop_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
        check("endrop_hs", 32'(vga_hs), 32'd1);
        check("endrop_vs", 32'(vga_vs), 32'd1);
        cycle(1'b0);
        repeat (FRAME + 20) cycle(1'b1);

        cycle(1'b0);
        pal_ff = 1'b0;
        cycle(1'b0);

        // Randomized enable bursts and gaps.
        repeat (8) begin
            n = int'($urandom_range(1, 150));
            repeat (n) cycle(1'b1);
            n = int'($urandom_range(1, 4));
            repeat (n) cycle(1'b0);
        end

        // Asynchronous reset between clock edges, mid-line.
        repeat (HT + 3) cycle(1'b1);
        repeat (FRAME / 2) cycle(1'b1);
        @(posedge clk);
        #2;
        active = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_pins("async_rst");
        sb.delete();
        @(negedge clk);
        release_rst();
        repeat (FRAME + 8) cycle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
